// File: rtl/fwd_sel_gen.sv
// fwd_sel_gen -- ALU-operand forwarding-select and load-use stall generator
// for a 5-stage MIPS pipeline.
//
// Tracks the destination register of the instructions in EX and MEM, and
// registers the forwarding selects for the instruction entering EX. The
// selects are therefore valid in the cycle that instruction occupies EX.
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous, active-high
//   id_valid      ID holds a real instruction
//   id_rs/id_rt   ID source registers
//   id_uses_rt    ID instruction reads rt as an ALU operand
//   id_dst        ID destination register (after RegDst mux)
//   id_reg_write  ID instruction writes the register file
//   id_mem_read   ID instruction is a load
//   id_flush      squash the ID instruction (taken branch/jump)
//   ex_fwd_a_sel  EX operand A select: 00 regfile, 01 EX/MEM ALU result,
//                 10 MEM/WB write data
//   ex_fwd_b_sel  EX operand B select, same encoding
//   stall         hold PC and IF/ID this cycle (combinational)
//   ex_bubble     EX holds an injected bubble (registered)
module fwd_sel_gen #(
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_flush,
  output logic [1:0]        ex_fwd_a_sel,
  output logic [1:0]        ex_fwd_b_sel,
  output logic              stall,
  output logic              ex_bubble
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  // Only the EX and MEM copies influence any output: a producer in EX will be
  // in MEM when the consumer reaches EX (01), a producer in MEM will be in WB
  // (10). An instruction already in WB has written the register file by the
  // time the consumer reads it, so no WB copy is kept. The load flag is only
  // needed in EX, where the load-use check happens.
  logic              ex_v,  mem_v;
  logic [REG_AW-1:0] ex_dst, mem_dst;
  logic              ex_wr, mem_wr;
  logic              ex_ld;

  logic              ex_prod;   // EX holds a forwardable producer
  logic              mem_prod;  // MEM holds a forwardable producer
  logic              insert_bubble;
  logic [1:0]        sel_a, sel_b;

  // Register 0 is never a producer, so it neither forwards nor stalls.
  assign ex_prod  = ex_v  & ex_wr  & (ex_dst  != '0);
  assign mem_prod = mem_v & mem_wr & (mem_dst != '0);

  always_comb begin
    stall = ex_prod & ex_ld & id_valid & ~id_flush &
            ((ex_dst == id_rs) | (id_uses_rt & (ex_dst == id_rt)));
  end

  // Nearest producer wins. The B select is computed regardless of
  // id_uses_rt because the store-data path also consumes it.
  always_comb begin
    sel_a = SEL_RF;
    if (ex_prod && ex_dst == id_rs)        sel_a = SEL_MEM;
    else if (mem_prod && mem_dst == id_rs) sel_a = SEL_WB;
  end

  always_comb begin
    sel_b = SEL_RF;
    if (ex_prod && ex_dst == id_rt)        sel_b = SEL_MEM;
    else if (mem_prod && mem_dst == id_rt) sel_b = SEL_WB;
  end

  assign insert_bubble = stall | id_flush | ~id_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_v         <= 1'b0;
      ex_dst       <= '0;
      ex_wr        <= 1'b0;
      ex_ld        <= 1'b0;
      mem_v        <= 1'b0;
      mem_dst      <= '0;
      mem_wr       <= 1'b0;
      ex_fwd_a_sel <= SEL_RF;
      ex_fwd_b_sel <= SEL_RF;
      ex_bubble    <= 1'b0;
    end else begin
      mem_v   <= ex_v;
      mem_dst <= ex_dst;
      mem_wr  <= ex_wr;
      if (insert_bubble) begin
        ex_v         <= 1'b0;
        ex_dst       <= '0;
        ex_wr        <= 1'b0;
        ex_ld        <= 1'b0;
        ex_fwd_a_sel <= SEL_RF;
        ex_fwd_b_sel <= SEL_RF;
        // An empty ID slot is not an injected bubble; stall or flush is.
        ex_bubble    <= stall | id_flush;
      end else begin
        ex_v         <= 1'b1;
        ex_dst       <= id_dst;
        ex_wr        <= id_reg_write;
        ex_ld        <= id_mem_read;
        ex_fwd_a_sel <= sel_a;
        ex_fwd_b_sel <= sel_b;
        ex_bubble    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fwd_sel_gen.sv
// tb_fwd_sel_gen -- directed self-checking bench for fwd_sel_gen.
// Inputs change 1 time unit after the rising edge; registered outputs are
// read 1 unit after the edge, the combinational stall just before an edge.
module tb_fwd_sel_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_dst;
  logic       id_uses_rt, id_reg_write, id_mem_read, id_flush;
  logic [1:0] ex_fwd_a_sel, ex_fwd_b_sel;
  logic       stall, ex_bubble;

  int n_checks = 0;
  int n_fail   = 0;

  fwd_sel_gen #(.REG_AW(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .id_dst       (id_dst),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .id_flush     (id_flush),
    .ex_fwd_a_sel (ex_fwd_a_sel),
    .ex_fwd_b_sel (ex_fwd_b_sel),
    .stall        (stall),
    .ex_bubble    (ex_bubble)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction in ID (stimulus only).
  task automatic put(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                     input logic urt, input logic [4:0] dst, input logic wr,
                     input logic ld, input logic fl);
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rt = urt;
    id_dst = dst; id_reg_write = wr; id_mem_read = ld; id_flush = fl;
    #1;
  endtask

  task automatic idle();
    put(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    idle();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    tick(); tick();
    reset = 1'b0;
    #1;
    n_checks++; if (ex_fwd_a_sel !== 2'b00) begin n_fail++; $display("FAIL reset_a_sel got %b exp 00", ex_fwd_a_sel); end
    n_checks++; if (ex_fwd_b_sel !== 2'b00) begin n_fail++; $display("FAIL reset_b_sel got %b exp 00", ex_fwd_b_sel); end
    n_checks++; if (ex_bubble !== 1'b0) begin n_fail++; $display("FAIL reset_bubble got %b exp 0", ex_bubble); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b exp 0", stall); end
  endtask

  // add r3,r1,r2 ; add r4,r3,r1
  task automatic test_ex_fwd();
    put(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    n_checks++; if (ex_fwd_a_sel !== 2'b00) begin n_fail++; $display("FAIL exfwd_first_a got %b exp 00", ex_fwd_a_sel); end
    put(1'b1, 5'd3, 5'd1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL exfwd_stall got %b exp 0", stall); end
    tick();
    n_checks++; if (ex_fwd_a_sel !== 2'b01) begin n_fail++; $display("FAIL exfwd_a got %b exp 01", ex_fwd_a_sel); end
    n_checks++; if (ex_fwd_b_sel !== 2'b00) begin n_fail++; $display("FAIL exfwd_b got %b exp 00", ex_fwd_b_sel); end
    drain();
  endtask

  // add r3,r1,r2 ; nop ; sub r5,r1,r3
  task automatic test_mem_fwd();
    put(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    put(1'b1, 5'd1, 5'd3, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    n_checks++; if (ex_fwd_a_sel !== 2'b00) begin n_fail++; $display("FAIL memfwd_a got %b exp 00", ex_fwd_a_sel); end
    n_checks++; if (ex_fwd_b_sel !== 2'b10) begin n_fail++; $display("FAIL memfwd_b got %b exp 10", ex_fwd_b_sel); end
    drain();
  endtask

  // lw r2,0(r1) ; add r6,r2,r2
  task automatic test_load_use();
    put(1'b1, 5'd1, 5'd2, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0);
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_pre_stall got %b exp 0", stall); end
    tick();
    put(1'b1, 5'd2, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall got %b exp 1", stall); end
    tick();
    n_checks++; if (ex_bubble !== 1'b1) begin n_fail++; $display("FAIL lu_bubble got %b exp 1", ex_bubble); end
    n_checks++; if (ex_fwd_a_sel !== 2'b00) begin n_fail++; $display("FAIL lu_bubble_a got %b exp 00", ex_fwd_a_sel); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_stall_once got %b exp 0", stall); end
    tick();
    n_checks++; if (ex_fwd_a_sel !== 2'b10) begin n_fail++; $display("FAIL lu_a got %b exp 10", ex_fwd_a_sel); end
    n_checks++; if (ex_fwd_b_sel !== 2'b10) begin n_fail++; $display("FAIL lu_b got %b exp 10", ex_fwd_b_sel); end
    n_checks++; if (ex_bubble !== 1'b0) begin n_fail++; $display("FAIL lu_bubble_clr got %b exp 0", ex_bubble); end
    drain();
  endtask

  // add r7 ; add r7 ; or r8,r7,r0
  task automatic test_nearest();
    put(1'b1, 5'd1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    tick();
    put(1'b1, 5'd1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    tick();
    put(1'b1, 5'd7, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    tick();
    n_checks++; if (ex_fwd_a_sel !== 2'b01) begin n_fail++; $display("FAIL nearest_a got %b exp 01", ex_fwd_a_sel); end
    n_checks++; if (ex_fwd_b_sel !== 2'b00) begin n_fail++; $display("FAIL nearest_b_r0 got %b exp 00", ex_fwd_b_sel); end
    drain();
  endtask

  // Writes to r0 never forward or stall.
  task automatic test_reg0();
    put(1'b1, 5'd1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    put(1'b1, 5'd0, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    tick();
    n_checks++; if (ex_fwd_a_sel !== 2'b00) begin n_fail++; $display("FAIL r0_a got %b exp 00", ex_fwd_a_sel); end
    put(1'b1, 5'd1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    tick();
    put(1'b1, 5'd0, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL r0_stall got %b exp 0", stall); end
    drain();
  endtask

  // lw r9 ; dependent instruction flushed in ID
  task automatic test_flush();
    put(1'b1, 5'd1, 5'd9, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0);
    tick();
    put(1'b1, 5'd9, 5'd9, 1'b1, 5'd10, 1'b1, 1'b0, 1'b1);
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall got %b exp 0", stall); end
    tick();
    n_checks++; if (ex_bubble !== 1'b1) begin n_fail++; $display("FAIL flush_bubble got %b exp 1", ex_bubble); end
    n_checks++; if (ex_fwd_a_sel !== 2'b00) begin n_fail++; $display("FAIL flush_a got %b exp 00", ex_fwd_a_sel); end
    n_checks++; if (ex_fwd_b_sel !== 2'b00) begin n_fail++; $display("FAIL flush_b got %b exp 00", ex_fwd_b_sel); end
    idle();
    tick();
    n_checks++; if (ex_bubble !== 1'b0) begin n_fail++; $display("FAIL idle_bubble got %b exp 0", ex_bubble); end
    drain();
  endtask

  // Reset asserted while a load-use stall is pending.
  task automatic test_reset_mid_stall();
    put(1'b1, 5'd1, 5'd2, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0);
    tick();
    put(1'b1, 5'd2, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rms_stall_pre got %b exp 1", stall); end
    reset = 1'b1;
    tick();
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rms_stall got %b exp 0", stall); end
    n_checks++; if (ex_fwd_a_sel !== 2'b00) begin n_fail++; $display("FAIL rms_a got %b exp 00", ex_fwd_a_sel); end
    n_checks++; if (ex_bubble !== 1'b0) begin n_fail++; $display("FAIL rms_bubble got %b exp 0", ex_bubble); end
    reset = 1'b0;
    // MEM must be empty too: the load must not reappear as a WB producer.
    tick();
    n_checks++; if (ex_fwd_a_sel !== 2'b00) begin n_fail++; $display("FAIL rms_mem_clr_a got %b exp 00", ex_fwd_a_sel); end
    n_checks++; if (ex_fwd_b_sel !== 2'b00) begin n_fail++; $display("FAIL rms_mem_clr_b got %b exp 00", ex_fwd_b_sel); end
    drain();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_ex_fwd();
    test_mem_fwd();
    test_load_use();
    test_nearest();
    test_reg0();
    test_flush();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
